// File: rtl/xu0_bprm_seq_if.sv
// Issue/writeback handshake bundle for the bpermd sequencer.
// The master side is the XU0 issue/writeback logic; the slave side is the sequencer.
interface xu0_bprm_seq_if #(
  parameter int ITAG_W = 7
);
  logic              req_val;
  logic              req_rdy;
  logic [0:63]       req_rs;
  logic [0:63]       req_rb;
  logic [0:ITAG_W-1] req_itag;

  logic              rslt_val;
  logic              rslt_rdy;
  logic [0:63]       rslt_data;
  logic [0:ITAG_W-1] rslt_itag;

  modport master (
    output req_val, req_rs, req_rb, req_itag, rslt_rdy,
    input  req_rdy, rslt_val, rslt_data, rslt_itag
  );

  modport slave (
    input  req_val, req_rs, req_rb, req_itag, rslt_rdy,
    output req_rdy, rslt_val, rslt_data, rslt_itag
  );
endinterface

// File: rtl/xu0_bprm_seq.sv
// Multi-cycle bpermd sequencer: walks the 8 index bytes of RS through one shared bit-permute unit.
// Optional macro XU0_BPRM_SEQ_B2B_EN lets a new op be accepted while the previous result drains.
module xu0_bprm_seq #(
  parameter int ITAG_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  xu0_bprm_seq_if.slave bus,
  output logic [0:63] bprm_a,
  output logic [0:7]  bprm_s,
  input  logic        bprm_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic [0:2]        cnt_reg;
  logic [0:63]       rs_q;
  logic [0:63]       rb_q;
  logic [0:ITAG_W-1] itag_q;
  logic [0:7]        res_q;

  logic              rslt_val_reg;
  logic [0:63]       rslt_data_reg;
  logic [0:ITAG_W-1] rslt_itag_reg;

  logic              rdy_raw;
  logic              accept;

`ifdef XU0_BPRM_SEQ_B2B_EN
  // A draining result frees the sequencer in the same cycle, so the next op can start.
  assign rdy_raw = (state_reg == IDLE) | ((state_reg == DONE) & bus.rslt_rdy);
`else
  assign rdy_raw = (state_reg == IDLE);
`endif

  assign bus.req_rdy = rdy_raw & ~flush;
  assign accept      = bus.req_val & bus.req_rdy;

  // Permute unit inputs come straight from the latched operands, forced to zero outside RUN.
  assign bprm_a = (state_reg == RUN) ? rb_q : '0;
  assign bprm_s = (state_reg == RUN) ? rs_q[{cnt_reg, 3'b000} +: 8] : '0;

  assign bus.rslt_val  = rslt_val_reg;
  assign bus.rslt_data = rslt_data_reg;
  assign bus.rslt_itag = rslt_itag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rs_q          <= '0;
      rb_q          <= '0;
      itag_q        <= '0;
      res_q         <= '0;
      rslt_val_reg  <= 1'b0;
      rslt_data_reg <= '0;
      rslt_itag_reg <= '0;
    end else if (flush) begin
      // Flush abandons whatever is in flight, including a result being handed over this cycle.
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rslt_val_reg  <= 1'b0;
      rslt_data_reg <= '0;
      rslt_itag_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rs_q      <= bus.req_rs;
            rb_q      <= bus.req_rb;
            itag_q    <= bus.req_itag;
            cnt_reg   <= '0;
            res_q     <= '0;
            state_reg <= RUN;
          end
        end

        RUN: begin
          res_q[cnt_reg] <= bprm_y;
          cnt_reg        <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            // Last bit is taken directly from the unit so the result is ready on entering DONE.
            state_reg     <= DONE;
            rslt_val_reg  <= 1'b1;
            rslt_data_reg <= {56'b0, res_q[0:6], bprm_y};
            rslt_itag_reg <= itag_q;
          end
        end

        DONE: begin
          if (bus.rslt_rdy) begin
            rslt_val_reg  <= 1'b0;
            rslt_data_reg <= '0;
            rslt_itag_reg <= '0;
            if (accept) begin
              rs_q      <= bus.req_rs;
              rb_q      <= bus.req_rb;
              itag_q    <= bus.req_itag;
              cnt_reg   <= '0;
              res_q     <= '0;
              state_reg <= RUN;
            end else begin
              state_reg <= IDLE;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xu0_bprm_seq.sv
// Scoreboard bench for xu0_bprm_seq with a behavioural bpermd model and a bit-permute unit model.
module tb_xu0_bprm_seq;
  localparam int ITAG_W = 7;
`ifdef XU0_BPRM_SEQ_B2B_EN
  localparam int EXP_PERIOD = 9;
`else
  localparam int EXP_PERIOD = 10;
`endif

  typedef struct {
    logic [63:0]       data;
    logic [ITAG_W-1:0] itag;
    int                acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [0:63] bprm_a;
  logic [0:7]  bprm_s;
  logic        bprm_y;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   last_acc = 0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];

  xu0_bprm_seq_if #(.ITAG_W(ITAG_W)) bus ();

  xu0_bprm_seq #(.ITAG_W(ITAG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bus    (bus),
    .bprm_a (bprm_a),
    .bprm_s (bprm_s),
    .bprm_y (bprm_y)
  );

  // Single-bit permute unit: index >= 64 yields 0.
  assign bprm_y = (bprm_s[0:1] == 2'b00) ? bprm_a[bprm_s[2:7]] : 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_bpermd(input logic [63:0] rs, input logic [63:0] rb);
    logic [63:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx = int'((rs >> (56 - 8 * i)) & 64'hFF);
      if (idx < 64) r[7 - i] = rb[63 - idx];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [63:0] rs, input logic [63:0] rb, input logic [ITAG_W-1:0] itag);
    exp_t e;
    bit   done;
    done         = 1'b0;
    bus.req_val  = 1'b1;
    bus.req_rs   = rs;
    bus.req_rb   = rb;
    bus.req_itag = itag;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (bus.req_rdy && !flush) begin
        e.data   = ref_bpermd(rs, rb);
        e.itag   = itag;
        e.acc    = cyc;
        last_acc = cyc;
        exp_q.push_back(e);
        done = 1'b1;
        $display("op  accept rs=%h rb=%h itag=%0d exp=%h cycle=%0d", rs, rb, itag, e.data, cyc);
      end
      @(posedge clk); #1;
    end
    bus.req_val = 1'b0;
    chk("accept", 64'(done), 64'd1);
  endtask

  task automatic wait_result();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.rslt_val) seen = 1'b1;
    end
    @(posedge clk); #1;
    chk("result_seen", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: checks each new result against the scoreboard and held results for stability.
  initial begin
    bit                hold;
    logic [63:0]       hd;
    logic [ITAG_W-1:0] hi;
    hold = 1'b0;
    hd   = '0;
    hi   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_val", 64'(bus.rslt_val), 64'd1);
          chk("hold_data", 64'(bus.rslt_data), hd);
          chk("hold_itag", 64'(bus.rslt_itag), 64'(hi));
        end else if (bus.rslt_val) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rslt", 64'(bus.rslt_val), 64'd0);
          end else begin
            chk("latency", 64'(cyc - exp_q[0].acc), 64'd9);
            chk("rslt_data", 64'(bus.rslt_data), exp_q[0].data);
            chk("rslt_itag", 64'(bus.rslt_itag), 64'(exp_q[0].itag));
            $display("rsl data=%h itag=%0d cycle=%0d", bus.rslt_data, bus.rslt_itag, cyc);
          end
        end
        if (bus.rslt_val && !bus.rslt_rdy && !flush)
          chk("stall_req_rdy", 64'(bus.req_rdy), 64'd0);
        if (bus.rslt_val && bus.rslt_rdy && !flush && exp_q.size() > 0)
          void'(exp_q.pop_front());
        hold = bus.rslt_val && !bus.rslt_rdy && !flush;
        hd   = bus.rslt_data;
        hi   = bus.rslt_itag;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.rslt_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rs;
    logic [63:0] rb;
    int          prev_acc;

    bus.req_val  = 1'b0;
    bus.req_rs   = '0;
    bus.req_rb   = '0;
    bus.req_itag = '0;
    bus.rslt_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("rst_rslt_val", 64'(bus.rslt_val), 64'd0);
    chk("rst_rslt_data", 64'(bus.rslt_data), 64'd0);
    chk("rst_rslt_itag", 64'(bus.rslt_itag), 64'd0);
    chk("rst_bprm_s", 64'(bprm_s), 64'd0);
    chk("rst_bprm_a", 64'(bprm_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity-ordered indices and out-of-range indices
    send(64'h0001020304050607, 64'hA500000000000000, 7'd5);
    drain();
    send(64'h40FF3F0080C17F01, 64'h8000000000000001, 7'd9);
    drain();

    // Writeback stall: result must stay put while rslt_rdy is low
    bus.rslt_rdy = 1'b0;
    send(64'h0706050403020100, 64'h123456789ABCDEF0, 7'd33);
    wait_result();
    repeat (5) @(posedge clk);
    #1;
    bus.rslt_rdy = 1'b1;
    drain();

    // Flush in RUN cycle 4 with a competing request
    send(64'h3F3E3D3C3B3A3938, 64'hFFFF0000FFFF0000, 7'd17);
    repeat (4) @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.req_val  = 1'b1;
    bus.req_rs   = 64'h0102030405060708;
    bus.req_itag = 7'd99;
    exp_q.delete();
    @(negedge clk);
    chk("flush_run_req_rdy", 64'(bus.req_rdy), 64'd0);
    @(posedge clk); #1;
    flush       = 1'b0;
    bus.req_val = 1'b0;
    @(negedge clk);
    chk("post_flush_req_rdy", 64'(bus.req_rdy), 64'd1);
    chk("post_flush_bprm_a", 64'(bprm_a), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    send(64'h0010203038001828, 64'hDEADBEEFCAFEF00D, 7'd42);
    drain();

    // Flush while DONE with rslt_rdy high drops the result
    bus.rslt_rdy = 1'b0;
    send(64'h0203040506070809, 64'hF0F0F0F0F0F0F0F0, 7'd11);
    wait_result();
    bus.rslt_rdy = 1'b1;
    flush        = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("flush_done_req_rdy", 64'(bus.req_rdy), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_drop", 64'(bus.rslt_val), 64'd0);
    chk("flush_done_idle", 64'(bus.req_rdy), 64'd1);
    @(posedge clk); #1;

    // Back-to-back op period
    prev_acc = 0;
    for (int n = 0; n < 5; n++) begin
      rs = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      send(rs, rb, 7'(n + 60));
      if (n > 0) chk("period", 64'(last_acc - prev_acc), 64'(EXP_PERIOD));
      prev_acc = last_acc;
    end
    drain();

    // Randomized ops with random writeback backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rs = '0;
      for (int b = 0; b < 8; b++) rs = (rs << 8) | 64'($urandom_range(0, 95));
      rb = {$urandom, $urandom};
      send(rs, rb, 7'($urandom_range(0, 127)));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    bus.rslt_rdy = 1'b1;
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
